// File: rtl/dcache_pkg.sv
// Shared FSM type and default geometry for the direct-mapped data cache.
// Address fields (low to high): byte offset, word-in-line, line index, tag.
package dcache_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRefill = 2'd1,
    StWrite  = 2'd2,
    StDone   = 2'd3
  } state_e;

  localparam int unsigned CacheAddrWidth     = 32;
  localparam int unsigned CacheDataWidth     = 32;
  localparam int unsigned CacheIndexBits     = 6;
  localparam int unsigned CacheWordsPerBlock = 4;

  localparam int unsigned OFFSET_BITS = $clog2(CacheDataWidth / 8);
  localparam int unsigned WORD_BITS   = $clog2(CacheWordsPerBlock);
  localparam int unsigned TAG_BITS    = CacheAddrWidth - CacheIndexBits - WORD_BITS - OFFSET_BITS;

endpackage

// File: rtl/dcache_if.sv
// Datapath-side and main-memory-side signals of the data cache.
// The controller takes the master view; datapath and memory sit on the slave view.
interface dcache_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  MemRead;
  logic                  MemWrite;
  logic [ADDR_WIDTH-1:0] Addr;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [DATA_WIDTH-1:0] ReadData;
  logic                  Stall;

  logic                  MemReq;
  logic                  MemWe;
  logic [ADDR_WIDTH-1:0] MemAddr;
  logic [DATA_WIDTH-1:0] MemWData;
  logic [DATA_WIDTH-1:0] MemRData;
  logic                  MemReady;

  modport master (
    input  MemRead, MemWrite, Addr, WriteData, MemRData, MemReady,
    output ReadData, Stall, MemReq, MemWe, MemAddr, MemWData
  );

  modport slave (
    output MemRead, MemWrite, Addr, WriteData, MemRData, MemReady,
    input  ReadData, Stall, MemReq, MemWe, MemAddr, MemWData
  );

endinterface

// File: rtl/dcache_array.sv
// Valid/tag/data storage: one combinational read port, one synchronous write port.
// Only the valid bits are cleared by reset; tags and data keep their contents.
module dcache_array #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned WORD_BITS  = 2,
  parameter int unsigned TAG_BITS   = 22,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [INDEX_BITS-1:0] rd_index_i,
  input  logic [WORD_BITS-1:0]  rd_word_i,
  output logic                  rd_valid_o,
  output logic [TAG_BITS-1:0]   rd_tag_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic                  word_we_i,
  input  logic                  tag_we_i,
  input  logic [INDEX_BITS-1:0] wr_index_i,
  input  logic [WORD_BITS-1:0]  wr_word_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i
);

  localparam int unsigned Lines = 1 << INDEX_BITS;
  localparam int unsigned Words = 1 << WORD_BITS;

  logic [Lines-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q  [Lines];
  logic [DATA_WIDTH-1:0] data_q [Lines][Words];

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i][rd_word_i];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (tag_we_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (tag_we_i) begin
      tag_q[wr_index_i] <= wr_tag_i;
    end
    if (word_we_i) begin
      data_q[wr_index_i][wr_word_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Define DCACHE_STATS_EN to build the saturating HitCount/MissCount counters.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = CacheAddrWidth,
  parameter int unsigned DATA_WIDTH      = CacheDataWidth,
  parameter int unsigned INDEX_BITS      = CacheIndexBits,
  parameter int unsigned WORDS_PER_BLOCK = CacheWordsPerBlock
) (
  input  logic        CLK,
  input  logic        RST,
  dcache_if.master    bus,
  output logic [31:0] HitCount,
  output logic [31:0] MissCount
);

  localparam int unsigned OffsetBits = $clog2(DATA_WIDTH / 8);
  localparam int unsigned WordBits   = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned TagBits    = ADDR_WIDTH - INDEX_BITS - WordBits - OffsetBits;
  localparam int unsigned LastBeat   = WORDS_PER_BLOCK - 1;

  logic [TagBits-1:0]    addr_tag;
  logic [INDEX_BITS-1:0] addr_index;
  logic [WordBits-1:0]   addr_word;
  logic                  unused_offset;

  state_e                state_q, state_d;
  logic [WordBits-1:0]   cnt_q, cnt_d;
  logic [WordBits-1:0]   word_q, word_d;
  logic [TagBits-1:0]    tag_q, tag_d;
  logic [INDEX_BITS-1:0] index_q, index_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic                  relookup_q, relookup_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic [INDEX_BITS-1:0] rd_index;
  logic [WordBits-1:0]   rd_word;
  logic                  rd_valid;
  logic [TagBits-1:0]    rd_tag;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [TagBits-1:0]    cmp_tag;
  logic                  hit;

  logic                  word_we;
  logic                  tag_we;
  logic [WordBits-1:0]   wr_word;
  logic [DATA_WIDTH-1:0] wr_data;

  logic                  stall;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  hit_evt;
  logic                  miss_evt;

  assign addr_word     = bus.Addr[OffsetBits +: WordBits];
  assign addr_index    = bus.Addr[OffsetBits + WordBits +: INDEX_BITS];
  assign addr_tag      = bus.Addr[ADDR_WIDTH-1 -: TagBits];
  assign unused_offset = ^bus.Addr[OffsetBits-1:0];

  // Look up the live address in IDLE, the latched line once a miss/store is in flight.
  assign rd_index = (state_q == StIdle) ? addr_index : index_q;
  assign rd_word  = (state_q == StIdle) ? addr_word : word_q;
  assign cmp_tag  = (state_q == StIdle) ? addr_tag : tag_q;
  assign hit      = rd_valid && (rd_tag == cmp_tag);

  dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .WORD_BITS  (WordBits),
    .TAG_BITS   (TagBits),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .rd_index_i (rd_index),
    .rd_word_i  (rd_word),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .word_we_i  (word_we),
    .tag_we_i   (tag_we),
    .wr_index_i (index_q),
    .wr_word_i  (wr_word),
    .wr_data_i  (wr_data),
    .wr_tag_i   (tag_q)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    tag_d      = tag_q;
    index_d    = index_q;
    req_d      = req_q;
    we_d       = we_q;
    relookup_d = relookup_q;
    maddr_d    = maddr_q;
    wdata_d    = wdata_q;
    stall      = 1'b0;
    read_data  = '0;
    hit_evt    = 1'b0;
    miss_evt   = 1'b0;
    word_we    = 1'b0;
    tag_we     = 1'b0;
    wr_word    = cnt_q;
    wr_data    = bus.MemRData;

    unique case (state_q)
      StIdle: begin
        relookup_d = 1'b0;
        if (bus.MemWrite) begin
          stall   = 1'b1;
          state_d = StWrite;
          req_d   = 1'b1;
          we_d    = 1'b1;
          maddr_d = {bus.Addr[ADDR_WIDTH-1:OffsetBits], {OffsetBits{1'b0}}};
          wdata_d = bus.WriteData;
          tag_d   = addr_tag;
          index_d = addr_index;
          word_d  = addr_word;
        end else if (bus.MemRead) begin
          if (hit) begin
            read_data = rd_data;
            hit_evt   = !relookup_q;
          end else begin
            stall    = 1'b1;
            miss_evt = 1'b1;
            state_d  = StRefill;
            cnt_d    = '0;
            req_d    = 1'b1;
            we_d     = 1'b0;
            maddr_d  = {addr_tag, addr_index, {WordBits{1'b0}}, {OffsetBits{1'b0}}};
            tag_d    = addr_tag;
            index_d  = addr_index;
          end
        end
      end

      StRefill: begin
        stall = 1'b1;
        if (bus.MemReady) begin
          word_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          maddr_d = {tag_q, index_q, cnt_d, {OffsetBits{1'b0}}};
          if (cnt_q == WordBits'(LastBeat)) begin
            tag_we     = 1'b1;
            req_d      = 1'b0;
            relookup_d = 1'b1;
            state_d    = StIdle;
          end
        end
      end

      StWrite: begin
        stall = 1'b1;
        if (bus.MemReady) begin
          // No write-allocate: a resident line is patched, a missing one left alone.
          word_we = hit;
          wr_word = word_q;
          wr_data = wdata_q;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      word_q     <= '0;
      tag_q      <= '0;
      index_q    <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      relookup_q <= 1'b0;
      maddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      tag_q      <= tag_d;
      index_q    <= index_d;
      req_q      <= req_d;
      we_q       <= we_d;
      relookup_q <= relookup_d;
      maddr_q    <= maddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign bus.Stall    = stall & RST;
  assign bus.ReadData = RST ? read_data : '0;
  assign bus.MemReq   = req_q;
  assign bus.MemWe    = we_q;
  assign bus.MemAddr  = maddr_q;
  assign bus.MemWData = wdata_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_evt && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (miss_evt && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign HitCount  = hit_cnt_q;
  assign MissCount = miss_cnt_q;
`else
  logic unused_stats;

  assign unused_stats = hit_evt ^ miss_evt;
  assign HitCount     = '0;
  assign MissCount    = '0;
`endif

endmodule
